// File: rtl/lif_neuron_array_if.sv
// Handshake/data bundle between the current source and the LIF neuron array.
// Widths follow the array's parameters; the host side uses master, the array uses slave.
interface lif_neuron_array_if #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 16
);
    localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    logic                         en;
    logic [N_NEURONS*WIDTH-1:0]   current_in;
    logic [WIDTH-1:0]             threshold;
    logic                         cnt_clr;
    logic [N_NEURONS-1:0]         spike;
    logic [IW-1:0]                mem_idx;
    logic [WIDTH-1:0]             mem_out;
    logic                         upd_valid;
    logic [CNT_W-1:0]             spike_cnt;

    modport master (
        output en, current_in, threshold, cnt_clr,
        input  spike, mem_idx, mem_out, upd_valid, spike_cnt
    );

    modport slave (
        input  en, current_in, threshold, cnt_clr,
        output spike, mem_idx, mem_out, upd_valid, spike_cnt
    );
endinterface

// File: rtl/lif_neuron_array.sv
// Time-multiplexed leaky integrate-and-fire array: one neuron updated per enabled cycle, round-robin.
// Latency 1 cycle from the updating edge to spike/mem_out; en=0 simply stalls the rotation with no state loss.
module lif_neuron_array #(
    parameter int N_NEURONS  = 4,
    parameter int WIDTH      = 8,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    lif_neuron_array_if.slave   bus
);
    localparam int IW  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int RCW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    logic [WIDTH-1:0]     r_v   [N_NEURONS];
    logic [RCW-1:0]       r_rc  [N_NEURONS];
    logic [IW-1:0]        r_ptr;
    logic [N_NEURONS-1:0] r_spike;
    logic [IW-1:0]        r_idx;
    logic [WIDTH-1:0]     r_mem;
    logic                 r_valid;
    logic [CNT_W-1:0]     r_cnt;

    logic [WIDTH-1:0]     w_v;
    logic [WIDTH-1:0]     w_cur;
    logic [RCW-1:0]       w_rc;
    logic [WIDTH-1:0]     w_leaked;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_sat;
    logic                 w_refr;
    logic                 w_fire;
    logic [WIDTH-1:0]     w_new;

    // Mux out the state and input slice of the neuron under the pointer.
    always_comb begin
        w_v   = '0;
        w_cur = '0;
        w_rc  = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (r_ptr == IW'(k)) begin
                w_v   = r_v[k];
                w_cur = bus.current_in[k*WIDTH +: WIDTH];
                w_rc  = r_rc[k];
            end
        end
    end

    assign w_leaked = w_v - (w_v >> LEAK_SHIFT);
    assign w_sum    = {1'b0, w_leaked} + {1'b0, w_cur};
    assign w_sat    = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    assign w_refr   = (w_rc != '0);
    assign w_fire   = bus.en && !w_refr && (w_sat >= bus.threshold);
    assign w_new    = (w_refr || w_fire) ? '0 : w_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                r_v[k]  <= '0;
                r_rc[k] <= '0;
            end
            r_ptr   <= '0;
            r_spike <= '0;
            r_idx   <= '0;
            r_mem   <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_valid <= bus.en;
            for (int k = 0; k < N_NEURONS; k++) begin
                r_spike[k] <= w_fire && (r_ptr == IW'(k));
            end
            if (bus.en) begin
                r_idx <= r_ptr;
                r_mem <= w_new;
                r_ptr <= (r_ptr == IW'(N_NEURONS - 1)) ? '0 : r_ptr + 1'b1;
                for (int k = 0; k < N_NEURONS; k++) begin
                    if (r_ptr == IW'(k)) begin
                        r_v[k] <= w_new;
                        if (w_refr) begin
                            r_rc[k] <= w_rc - 1'b1;
                        end else if (w_fire) begin
                            r_rc[k] <= RCW'(REFRAC);
                        end
                    end
                end
            end
            // A clear wins over the old count but still records a same-cycle fire.
            if (bus.cnt_clr) begin
                r_cnt <= w_fire ? CNT_W'(1) : '0;
            end else if (w_fire && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.spike     = r_spike;
    assign bus.mem_idx   = r_idx;
    assign bus.mem_out   = r_mem;
    assign bus.upd_valid = r_valid;
    assign bus.spike_cnt = r_cnt;
endmodule
